bcd_serial_add_ctrl: RTL and testbench

//  Digit-serial sequencer for NDIG-digit packed-BCD addition. It time-shares one BCD digit adder
//  (bcd_digit_add) across all digits, LSD first, one digit per clock. Operands enter and the
//  (NDIG+1)-digit sum leaves through valid/ready handshakes. Sits between an operand source
//  (register file or UART parser) and a result sink, in place of a wide combinational adder.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_add.sv | 35 +++
 rtl/bcd_serial_add_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Shared definitions for the digit-serial BCD adder slice: the width of one
//   BCD digit, the controller state encoding and a digit validity helper.
//   No ports; imported by bcd_digit_add and bcd_serial_add_ctrl.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A nibble is a legal BCD digit when it holds 0..9.
  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return (d <= BCD_W'(9));
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
//   Combinational single-digit BCD adder: binary add of two digits plus a
//   carry-in, followed by the +6 decimal correction whenever the binary sum
//   exceeds 9.
// Ports
//   a, b  in   BCD_W  operand digits (0..9 for a meaningful result)
//   cin   in   1      carry from the less significant digit
//   f     out  BCD_W  result digit
//   cout  out  1      carry into the next digit
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] f,
  output logic             cout
);

  logic [BCD_W:0] raw;
  logic [BCD_W:0] adj;

  // Max legal raw sum is 9+9+1=19; after +6 that is 25, still inside 5 bits,
  // so the corrected value's top bit is the decimal carry.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    adj = raw;
    if (raw > (BCD_W+1)'(9)) begin
      adj = raw + (BCD_W+1)'(6);
    end
    cout = adj[BCD_W];
    f    = adj[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Digit-serial sequencer for NDIG-digit packed-BCD addition. One shared
//   bcd_digit_add is stepped LSD first, one digit per clock. Operands arrive
//   and the (NDIG+1)-digit sum leaves over valid/ready handshakes.
// Ports
//   clk        in   1          clock, all state on the rising edge
//   rst        in   1          asynchronous active-high reset
//   in_valid   in   1          operand pair valid
//   in_ready   out  1          controller idle and able to accept operands
//   a, b       in   4*NDIG     packed BCD operands, digit 0 in bits [3:0]
//   out_valid  out  1          result valid, held until out_ready
//   out_ready  in   1          sink takes the result
//   sum        out  4*NDIG+4   packed BCD sum, top digit is the final carry
//   err        out  1          some operand digit was above 9 (sum forced to 0)
//   busy       out  1          controller is not idle
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BCD_W*NDIG-1:0]   a,
  input  logic [BCD_W*NDIG-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BCD_W*NDIG+3:0]   sum,
  output logic                    err,
  output logic                    busy
);

  localparam int W     = BCD_W * NDIG;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t state;
  state_t next_state;

  logic [W-1:0]           a_sh;
  logic [W-1:0]           b_sh;
  logic [W-BCD_W-1:0]     acc;
  logic [W+BCD_W-1:0]     sum_reg;
  logic                   carry;
  logic [IDX_W-1:0]       idx;
  logic                   err_reg;

  logic                   in_err;
  logic                   last_digit;
  logic [BCD_W-1:0]       d_f;
  logic                   d_c;

  // Operands are shifted right each RUN cycle, so the digit under work is
  // always the bottom nibble of the shift registers.
  bcd_digit_add u_digit_add (
    .a    (a_sh[BCD_W-1:0]),
    .b    (b_sh[BCD_W-1:0]),
    .cin  (carry),
    .f    (d_f),
    .cout (d_c)
  );

  assign last_digit = (idx == IDX_W'(NDIG - 1));

  // Flag the operand pair if any digit of either operand is not 0..9.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!is_bcd(a[i*BCD_W +: BCD_W]) || !is_bcd(b[i*BCD_W +: BCD_W])) begin
        in_err = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. The output handshake returns to IDLE,
  // so a new operand can only be accepted the cycle after it.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (last_digit) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Datapath. Result digits are collected in acc while running; the visible
  // sum register is cleared on accept and written only on the final digit,
  // so a partial sum never reaches the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            acc     <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            err_reg <= in_err;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> BCD_W;
          b_sh  <= b_sh >> BCD_W;
          carry <= d_c;
          for (int i = 0; i < NDIG - 1; i++) begin
            if (idx == IDX_W'(i)) begin
              acc[i*BCD_W +: BCD_W] <= d_f;
            end
          end
          if (last_digit) begin
            if (err_reg) begin
              sum_reg <= '0;
            end else begin
              sum_reg <= {{(BCD_W-1){1'b0}}, d_c, d_f, acc};
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum = sum_reg;
  assign err = err_reg;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl
//   Directed bench for bcd_serial_add_ctrl (NDIG=4). Stimulus pushes the
//   hand-computed result into a queue when an operand pair is accepted; a
//   separate monitor pops and compares on every output handshake, and also
//   checks result latency and that outputs hold under backpressure.
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
  localparam int SW   = W + 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sum;
  logic          err;
  logic          busy;

  typedef struct {
    logic [SW-1:0] sum;
    logic          err;
    int            acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single place where comparisons are counted and failures reported.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive an operand pair, wait (bounded) for the accept edge, then queue
  // the expected result tagged with the cycle count of the accept edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [SW-1:0] es, input logic ee,
                               output int acc_cyc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int w = 0; w < 100; w++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      acc_cyc  = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    acc_cyc   = cyc;
    e.sum     = es;
    e.err     = ee;
    e.acc_cyc = acc_cyc;
    exp_q.push_back(e);
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: samples 1 time unit after each falling edge so it always sees
  // the inputs the stimulus drove on that edge.
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [SW-1:0] prev_sum   = '0;
  logic          prev_err   = 1'b0;
  exp_t          got;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_result", 32'd1, 32'd0);
        else checkOutput("latency", cyc - exp_q[0].acc_cyc, NDIG);
      end
      if (out_valid && prev_valid && !prev_ready) begin
        checkOutput("hold_sum", 32'(sum), 32'(prev_sum));
        checkOutput("hold_err", 32'(err), 32'(prev_err));
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("result_without_expectation", 32'd1, 32'd0);
        end else begin
          got = exp_q.pop_front();
          checkOutput("sum", 32'(sum), 32'(got.sum));
          checkOutput("err", 32'(err), 32'(got.err));
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_sum   = sum;
      prev_err   = err;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  int  acc1;
  int  acc2;
  bit  seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum",       32'(sum),       32'd0);
    checkOutput("rst_err",       32'(err),       32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic add 1234+5678");
    applyStimulus(16'h1234, 16'h5678, 20'h06912, 1'b0, acc1);
    checkOutput("run_busy",     32'(busy),     32'd1);
    checkOutput("run_in_ready", 32'(in_ready), 32'd0);
    waitIdle();

    $display("[TB] carry ripple, back-to-back");
    applyStimulus(16'h9999, 16'h0001, 20'h10000, 1'b0, acc1);
    applyStimulus(16'h9999, 16'h9999, 20'h19998, 1'b0, acc2);
    checkOutput("throughput", acc2 - acc1, NDIG + 2);
    waitIdle();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(16'h4321, 16'h1234, 20'h05555, 1'b0, acc1);
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_out_valid_seen", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_in_ready",  32'(in_ready),  32'd1);
    waitIdle();

    $display("[TB] invalid digit");
    applyStimulus(16'h12A4, 16'h0001, 20'h00000, 1'b1, acc1);
    waitIdle();

    $display("[TB] busy rejection");
    applyStimulus(16'h1234, 16'h5678, 20'h06912, 1'b0, acc1);
    a        = 16'h1111;
    b        = 16'h2222;
    in_valid = 1'b1;
    applyStimulus(16'h1111, 16'h2222, 20'h03333, 1'b0, acc2);
    checkOutput("busy_second_accept", acc2 - acc1, NDIG + 2);
    waitIdle();

    $display("[TB] reset mid-run");
    applyStimulus(16'h9876, 16'h1111, 20'h10987, 1'b0, acc1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_sum",       32'(sum),       32'd0);
    checkOutput("midrst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0005, 16'h0005, 20'h00010, 1'b0, acc1);
    waitIdle();

    if (exp_q.size() != 0) checkOutput("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
